// File: rtl/lfsr_encryptor.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_encryptor
//  Description : LFSR message cipher, forward (encrypt) direction. Reads a
//                plaintext message from data memory, builds a 64-byte
//                space-padded frame (preamble + message + post-padding),
//                XORs each byte with a 7-bit LFSR stream and writes the
//                ciphertext to data memory starting at CT_BASE.
//                Launched by a Start high->low handshake and reports
//                completion on Ack.
//  Build option: ENC_PARITY_EN - when defined, the ciphertext MSB carries
//                the even parity of the low seven cipher bits; otherwise
//                the plaintext MSB passes straight through.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_encryptor #(
    parameter int NUM_CHARS = 64,
    parameter int MSG_MAX   = 49,
    parameter int CT_BASE   = 64,
    parameter int PRE_MIN   = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    input  logic [3:0] PreLength,
    input  logic [6:0] LfsrPtrn,
    input  logic [6:0] LfsrInit,
    output logic       MemRdEn,
    output logic [7:0] MemRdAddr,
    input  logic [7:0] MemRdData,
    output logic       MemWrEn,
    output logic [7:0] MemWrAddr,
    output logic [7:0] MemWrData
);

    // ------------------------------------------------------------------
    // Constants sized to the datapath
    // ------------------------------------------------------------------
    localparam logic [5:0] C_LAST_IDX = 6'(NUM_CHARS - 1);
    localparam logic [7:0] C_MSG_MAX  = 8'(MSG_MAX);
    localparam logic [7:0] C_CT_BASE  = 8'(CT_BASE);
    localparam logic [3:0] C_PRE_MIN  = 4'(PRE_MIN);
    localparam logic [6:0] C_LFSR_SAFE = 7'h01;   // seed used when init is all-zero
    localparam logic [7:0] C_SPACE    = 8'h20;

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [5:0] r_idx;        // frame index i
    logic [6:0] r_lfsr;       // LFSR state for the current byte
    logic [3:0] r_pre;        // effective preamble length
    logic [6:0] r_taps;       // feedback tap mask
    logic       r_rd_issued;  // FETCH issued a read; data arrives in WRITE
    logic       r_armed;      // Start seen high since reset / last launch

    logic       w_launch;
    logic [3:0] w_pre_eff;
    logic [6:0] w_lfsr_seed;
    logic [7:0] w_idx_ext;
    logic [7:0] w_pre_ext;
    logic       w_in_msg;
    logic [7:0] w_msg_addr;
    logic [7:0] w_plain;
    logic [7:0] w_cipher;
    logic       w_ct_msb;
    logic       w_feedback;

    // ------------------------------------------------------------------
    // Shared combinational terms
    // ------------------------------------------------------------------
    assign w_launch    = (r_state == S_IDLE) && !Start && r_armed;
    assign w_pre_eff   = (PreLength < C_PRE_MIN) ? C_PRE_MIN : PreLength;
    assign w_lfsr_seed = (LfsrInit == 7'h00) ? C_LFSR_SAFE : LfsrInit;
    assign w_idx_ext   = {2'b00, r_idx};
    assign w_pre_ext   = {4'b0000, r_pre};
    // Message window: pre <= i < pre + MSG_MAX (8-bit compare, no overflow)
    assign w_in_msg    = (w_idx_ext >= w_pre_ext) &&
                         (w_idx_ext <  (w_pre_ext + C_MSG_MAX));
    assign w_msg_addr  = w_idx_ext - w_pre_ext;
    assign w_feedback  = ^(r_lfsr & r_taps);

    // Cipher byte formation for the WRITE cycle
    always_comb begin
        w_plain  = r_rd_issued ? MemRdData : C_SPACE;
        w_cipher = w_plain ^ {1'b0, r_lfsr};
`ifdef ENC_PARITY_EN
        w_ct_msb = ^w_cipher[6:0];
`else
        w_ct_msb = w_cipher[7];
`endif
    end

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Launch arming: a fresh launch needs Start to have been seen high
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_armed <= 1'b0;
        end else if (Start) begin
            r_armed <= 1'b1;
        end else if (w_launch) begin
            r_armed <= 1'b0;
        end
    end

    // Datapath registers: configuration capture, index and LFSR stepping
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_idx       <= 6'd0;
            r_lfsr      <= 7'd0;
            r_pre       <= 4'd0;
            r_taps      <= 7'd0;
            r_rd_issued <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_pre       <= w_pre_eff;
                    r_taps      <= LfsrPtrn;
                    r_lfsr      <= w_lfsr_seed;
                    r_idx       <= 6'd0;
                    r_rd_issued <= 1'b0;
                end
                S_FETCH: begin
                    r_rd_issued <= w_in_msg;
                end
                S_WRITE: begin
                    r_lfsr      <= {r_lfsr[5:0], w_feedback};
                    r_idx       <= r_idx + 6'd1;
                    r_rd_issued <= 1'b0;
                end
                default: begin
                    r_rd_issued <= 1'b0;
                end
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        Ack         = 1'b0;
        MemRdEn     = 1'b0;
        MemRdAddr   = 8'h00;
        MemWrEn     = 1'b0;
        MemWrAddr   = 8'h00;
        MemWrData   = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = Start ? S_IDLE : S_FETCH;
            end
            S_FETCH: begin
                if (w_in_msg) begin
                    MemRdEn   = 1'b1;
                    MemRdAddr = w_msg_addr;
                end
                w_state_nxt = Start ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                // The write in this cycle completes even when aborting
                MemWrEn   = 1'b1;
                MemWrAddr = C_CT_BASE + w_idx_ext;
                MemWrData = {w_ct_msb, w_cipher[6:0]};
                if (Start) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx == C_LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                Ack = 1'b1;
                if (Start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/lfsr_encryptor.md
Name: lfsr_encryptor

Overview:
- Hardware encryption engine for the Program #1 direction: the forward side of the LFSR message cipher whose ciphertext Program #2 decrypts.
- Reads a plaintext message from data memory and builds the 64-byte space-padded frame.
- XORs each byte with a 7-bit maximal-length LFSR stream and puts a parity bit in the MSB.
- Writes the ciphertext to data memory locations 64..127. Uses the same Start/Ack launch handshake as TopLevel.

Parameters:
- NUM_CHARS, 64, frame length in bytes (pre-padding + message + post-padding).
- MSG_MAX, 49, max message bytes read from memory. Frame positions beyond this are space.
- CT_BASE, 64, data-memory address of ciphertext byte 0.
- PRE_MIN, 10, minimum effective preamble length.

Ports:
- Clk  in  1  clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  high = hold idle; a low level in IDLE launches a run.
- Ack  out  1  run complete, held in DONE.
- PreLength  in  4  preamble byte count; sampled in LOAD.
- LfsrPtrn  in  7  feedback tap mask; sampled in LOAD.
- LfsrInit  in  7  LFSR start state; sampled in LOAD.
- MemRdEn  out  1  plaintext read strobe.
- MemRdAddr  out  8  plaintext address (message byte index).
- MemRdData  in  8  read data, valid exactly 1 cycle after MemRdEn.
- MemWrEn  out  1  ciphertext write strobe.
- MemWrAddr  out  8  CT_BASE + frame index.
- MemWrData  out  8  ciphertext byte.

Behaviour:
- Reset low (any time, including mid-run):
  - state = IDLE; index, LFSR, pre and taps registers = 0.
  - Ack, MemRdEn and MemWrEn = 0; MemRdAddr, MemWrAddr and MemWrData = 0.
- Reset released: no activity until Start is sampled high and then low.
- IDLE:
  - Start sampled low after Start has been sampled high since reset or since the last DONE → LOAD.
  - A Start that has been held low continuously does not relaunch.
- LOAD (1 cycle):
  - pre = max(PreLength, PRE_MIN).
  - taps = LfsrPtrn.
  - lfsr = (LfsrInit == 0) ? 7'h01 : LfsrInit.
  - i = 0.
  - → FETCH.
- FETCH (1 cycle):
  - If pre ≤ i < pre + MSG_MAX: MemRdEn = 1, MemRdAddr = i − pre.
  - Otherwise MemRdEn = 0 and plain = 8'h20.
  - → WRITE.
- WRITE (1 cycle):
  - plain = MemRdData when a read was issued in FETCH, else 8'h20.
  - c = plain ^ {1'b0, lfsr}.
  - MemWrEn = 1, MemWrAddr = CT_BASE + i, MemWrData = {^c[6:0], c[6:0]}.
  - lfsr ← {lfsr[5:0], ^(lfsr & taps)}.
  - i ← i + 1. If i == NUM_CHARS−1 → DONE, else → FETCH.
- DONE:
  - Ack = 1; no memory strobes.
  - Start sampled high → IDLE, and Ack falls the next cycle.
- Latency: the edge that samples the launch → Ack high after exactly 1 + 2·NUM_CHARS = 129 further edges.
- Exactly NUM_CHARS writes per run, in ascending address order. No write is ever outside CT_BASE..CT_BASE+NUM_CHARS−1.
- Start sampled high during LOAD, FETCH or WRITE:
  - Abort to IDLE; Ack stays 0.
  - A write already in that WRITE cycle completes; no later writes occur.
- Index wrap: i is 6 bits. The terminal compare is on NUM_CHARS−1, so i never wraps within a run.
- Input changes on PreLength, LfsrPtrn or LfsrInit after LOAD have no effect until the next run.

Optional Feature:
- ENC_PARITY_EN
  - Defined: MSB of each ciphertext byte = ^c[6:0], as above.
  - Undefined: MSB = c[7], i.e. plain[7] passed through. The parity XOR tree is absent.
  - All other timing and behaviour is identical in both builds.

Test Plan:
- Taps 0x72, init 0x3A, PreLength 13, plaintext "  f       A joke is a very serious thing." → byte 64 = 0x9A, byte 65 = 0x55. All 64 bytes match the bench model; decrypting with the Program #2 flow restores the padded frame.
- LfsrInit = 0, taps 0x60, PreLength 10 → LFSR starts at 0x01; byte 64 = 0x21.
- PreLength = 5 → treated as 10: first MemRdEn occurs for i = 10 with MemRdAddr 0; frame bytes 0..9 encrypt 0x20.
- Launch timing: Start 1→0 → Ack rises 129 edges after the launch edge; exactly 64 MemWrEn pulses. Start→1 → Ack drops; hold Start low without a rising edge → no relaunch.
- Reset asserted at write 30 → all outputs 0 immediately; no further writes. A fresh launch after reset produces a full correct frame.
- ENC_PARITY_EN undefined, plaintext byte 0x9F at a message position → MemWrData[7] = 1 regardless of the parity of c[6:0].
